uart_tx_8n1: RTL and testbench

- UART transmitter; the transmit-side counterpart of the board's RS232 receive path.
- Takes a byte from the control logic over a valid/ready handshake and serialises it on the RS232 line: LSB first, 1 start bit, 8 data bits, optional even parity, 1 or 2 stop bits.
- Integrated baud divider; needs no external bit-rate strobe.
- Sits between the host-facing command logic and the RS232 transmit pin.

---
 rtl/uart_tx_8n1.sv | 153 +++++++++++++++
 tb/tb_uart_tx_8n1.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_8n1.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// The baud divider is built in; every line level comes straight from a flop.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line high, tx_ready high, waiting for a byte
// S_START  | start bit (line low) for one bit period
// S_DATA   | D0..D7 shifted out, one bit period each
// S_PARITY | even parity bit (only when PARITY_EN=1)
// S_STOP   | line high for STOP_BITS bit periods, then back to idle
module uart_tx_8n1 #(
    parameter int BPS_DIV   = 5208,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rs232_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [15:0] BAUD_LAST = 16'(BPS_DIV - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      r_state;
    logic [15:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        r_tx;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;

    logic        w_tick;
    logic        w_accept;

    assign w_tick   = (r_baud_cnt == BAUD_LAST);
    assign w_accept = tx_valid & r_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_baud_cnt <= w_tick ? 16'd0 : r_baud_cnt + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    // tx_ready first rises on the clock after reset release
                    if (!r_ready) begin
                        r_ready <= 1'b1;
                    end else if (w_accept) begin
                        r_shift    <= tx_data;
                        r_parity   <= ^tx_data;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (w_tick) begin
                        r_tx      <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (w_tick) begin
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt <= '0;
                            r_busy    <= 1'b0;
                            r_ready   <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign rs232_tx = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Scoreboarded bench for uart_tx_8n1: two instances (8N1 and 8E2) at 4 clocks per bit,
// frames checked cycle by cycle against a reference built from the frame format.
module tb_uart_tx_8n1;
    localparam int B = 4;

    typedef struct {
        logic [7:0] data;
        int         acc;
        bit         abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       rdy0, rdy1, tx0, tx1, bsy0, bsy1, dn0, dn1;

    always #5 clk = ~clk;

    uart_tx_8n1 #(.BPS_DIV(B), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0),
        .tx_ready(rdy0), .rs232_tx(tx0), .tx_busy(bsy0), .tx_done(dn0)
    );

    uart_tx_8n1 #(.BPS_DIV(B), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
        .tx_ready(rdy1), .rs232_tx(tx1), .tx_busy(bsy1), .tx_done(dn1)
    );

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   free0, free1;
    int   exp_done0 = 0, exp_done1 = 0;
    int   got_done0 = 0, got_done1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && dn0) got_done0 <= got_done0 + 1;
        if (rst && dn1) got_done1 <= got_done1 + 1;
    end

    function automatic logic line(input int d);  return (d == 0) ? tx0  : tx1;  endfunction
    function automatic logic busy(input int d);  return (d == 0) ? bsy0 : bsy1; endfunction
    function automatic logic done(input int d);  return (d == 0) ? dn0  : dn1;  endfunction
    function automatic logic ready(input int d); return (d == 0) ? rdy0 : rdy1; endfunction
    function automatic int   qsize(input int d); return (d == 0) ? q0.size() : q1.size(); endfunction

    // dut0: start + 8 data + 1 stop; dut1: start + 8 data + parity + 2 stop
    function automatic int nbits(input int d);
        return (d == 0) ? 10 : 12;
    endfunction

    function automatic logic expbit(input int d, input logic [7:0] v, input int i);
        int ones;
        if (i == 0) return 1'b0;
        if (i <= 8) return v[i-1];
        if (d == 1 && i == 9) begin
            ones = 0;
            for (int k = 0; k < 8; k++) ones += int'(v[k]);
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon(input int d);
        logic prev;
        exp_t e;
        bit   ab;
        bit   ok;
        int   len;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !line(d)) begin
                e = '{8'h00, cyc, 1'b0};
                if (qsize(d) == 0) check(1'b0, $sformatf("dut%0d_unexpected_frame", d), 1, 0);
                else if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check(cyc == e.acc, $sformatf("dut%0d_start_cycle", d), cyc, e.acc);
                ab  = 1'b0;
                len = nbits(d) * B;
                for (int i = 0; i < nbits(d) && !ab; i++) begin
                    ok = 1'b1;
                    for (int k = 0; k < B && !ab; k++) begin
                        if (i != 0 || k != 0) @(negedge clk);
                        if (!rst) ab = 1'b1;
                        else if (line(d) !== expbit(d, e.data, i) || busy(d) !== 1'b1 || done(d) !== 1'b0)
                            ok = 1'b0;
                    end
                    if (!ab)
                        check(ok, $sformatf("dut%0d_byte%02h_bit%0d", d, e.data, i),
                              int'(line(d)), int'(expbit(d, e.data, i)));
                end
                check(ab == e.abort, $sformatf("dut%0d_abort_state", d), int'(ab), int'(e.abort));
                if (!ab) begin
                    @(negedge clk);
                    check(rst && done(d) === 1'b1 && busy(d) === 1'b0 && line(d) === 1'b1 && cyc == e.acc + len,
                          $sformatf("dut%0d_done_pulse", d), cyc, e.acc + len);
                end
                prev = ab ? 1'b1 : line(d);
            end else begin
                prev = line(d);
            end
        end
    endtask

    // Caller sits 1 time unit after a posedge; returns 1 unit after the accept edge.
    task automatic send(input int d, input logic [7:0] v, input bit hold, input bit abort);
        int a;
        int len;
        len = nbits(d) * B;
        if (d == 0) begin
            v0 = 1'b1; d0 = v;
            a = (cyc + 1 > free0) ? cyc + 1 : free0;
        end else begin
            v1 = 1'b1; d1 = v;
            a = (cyc + 1 > free1) ? cyc + 1 : free1;
        end
        while (cyc < a - 1) begin @(posedge clk); #1; end
        check(ready(d) === 1'b1, $sformatf("dut%0d_ready_before_accept", d), int'(ready(d)), 1);
        if (d == 0) q0.push_back('{v, a, abort});
        else        q1.push_back('{v, a, abort});
        @(posedge clk); #1;
        if (!hold) begin
            if (d == 0) v0 = 1'b0; else v1 = 1'b0;
        end
        if (d == 0) begin
            free0 = a + len + 1;
            if (!abort) exp_done0++;
        end else begin
            free1 = a + len + 1;
            if (!abort) exp_done1++;
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((busy(d) === 1'b1 || qsize(d) != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(n < 500, $sformatf("dut%0d_idle_timeout", d), n, 500);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a;
        bit hold;
        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        fork
            mon(0);
            mon(1);
        join_none

        repeat (2) @(posedge clk);
        #1;
        check(rdy0 === 1'b0 && rdy1 === 1'b0, "ready_low_in_reset", int'(rdy0), 0);
        check(tx0 === 1'b1 && tx1 === 1'b1, "line_high_in_reset", int'(tx0), 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        free0 = cyc + 2;
        free1 = cyc + 2;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check(line(d) === 1'b1,  $sformatf("dut%0d_reset_line", d),  int'(line(d)),  1);
            check(ready(d) === 1'b1, $sformatf("dut%0d_reset_ready", d), int'(ready(d)), 1);
            check(busy(d) === 1'b0,  $sformatf("dut%0d_reset_busy", d),  int'(busy(d)),  0);
            check(done(d) === 1'b0,  $sformatf("dut%0d_reset_done", d),  int'(done(d)),  0);
        end
        @(posedge clk); #1;

        send(0, 8'h55, 1'b0, 1'b0);
        wait_idle(0);

        // a valid pulse while busy must be dropped
        send(0, 8'hA5, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1 v0 = 1'b1; d0 = 8'hFF;
        @(posedge clk);
        #1 v0 = 1'b0;
        wait_idle(0);
        repeat (60) @(posedge clk);
        #1;
        check(tx0 === 1'b1 && bsy0 === 1'b0, "dut0_no_frame_after_ignored_valid", int'(tx0), 1);

        send(0, 8'hA5, 1'b1, 1'b0);
        send(0, 8'h3C, 1'b0, 1'b0);
        wait_idle(0);

        send(1, 8'h07, 1'b0, 1'b0);
        wait_idle(1);
        send(1, 8'h03, 1'b0, 1'b0);
        wait_idle(1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) begin
                hold = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
                send(d, 8'($urandom), hold, 1'b0);
                if (!hold) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            wait_idle(d);
        end

        // reset in the middle of D3 of a 0x00 frame
        send(0, 8'h00, 1'b0, 1'b1);
        a = cyc;
        while (cyc < a + 17) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check(tx0 === 1'b1 && bsy0 === 1'b0 && dn0 === 1'b0 && rdy0 === 1'b0,
              "dut0_async_reset_midframe", int'(tx0), 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        free0 = cyc + 2;
        free1 = cyc + 2;
        repeat (6) begin @(posedge clk); #1; end
        send(0, 8'h81, 1'b0, 1'b0);
        wait_idle(0);

        repeat (20) @(posedge clk);
        #1;
        check(tx0 === 1'b1 && tx1 === 1'b1, "final_line_idle", int'(tx0 & tx1), 1);
        check(q0.size() == 0 && q1.size() == 0, "final_queues_empty", q0.size() + q1.size(), 0);
        check(got_done0 == exp_done0, "dut0_done_count", got_done0, exp_done0);
        check(got_done1 == exp_done1, "dut1_done_count", got_done1, exp_done1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
